// File: rtl/seq_detector_param.sv
// Parametrised Moore serial sequence detector with a run-time loadable
// pattern, overlap/non-overlap select, sample enable and saturating count.
module seq_detector_param #(
    parameter int                 PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0] PAT_RESET = 4'b1001,
    parameter int                 CNT_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din,
    input  logic               en,
    input  logic               overlap_en,
    input  logic [PAT_LEN-1:0] pattern_in,
    input  logic               pattern_load,
    input  logic               count_clr,
    output logic               dout,
    output logic [CNT_W-1:0]   match_count,
    output logic               cnt_sat
);

    localparam int FW = $clog2(PAT_LEN + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

    logic [PAT_LEN-1:0] pat;
    logic [PAT_LEN-1:0] hist;
    logic [FW-1:0]      fill;

    logic [PAT_LEN-1:0] hist_n;
    logic [FW-1:0]      fill_n;
    logic               match;
    logic [CNT_W-1:0]   count_n;

    // Shift the new bit in and decide whether it completes the pattern.
    always_comb begin
        hist_n = {hist[PAT_LEN-2:0], din};
        fill_n = (fill == FULL) ? FULL : fill + 1'b1;
        match  = 1'b0;
        if (en && !pattern_load) begin
            match = (fill_n == FULL) && (hist_n == pat);
        end
    end

    // Next match count: clear wins over hold, a coinciding match gives one.
    always_comb begin
        count_n = match_count;
        if (count_clr) begin
            count_n = match ? CNT_W'(1) : '0;
        end else if (match && !cnt_sat) begin
            count_n = match_count + 1'b1;
        end
    end

    // Pattern, history, fill and the registered match bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat  <= PAT_RESET;
            hist <= '0;
            fill <= '0;
            dout <= 1'b0;
        end else if (pattern_load) begin
            pat  <= pattern_in;
            fill <= '0;
            dout <= 1'b0;
        end else if (en) begin
            hist <= hist_n;
            dout <= match;
            if (match && !overlap_en) begin
                fill <= '0;
            end else begin
                fill <= fill_n;
            end
        end
    end

    // Saturating counter with its saturation flag kept in lock-step.
    always_ff @(posedge clk) begin
        if (reset) begin
            match_count <= '0;
            cnt_sat     <= 1'b0;
        end else begin
            match_count <= count_n;
            cnt_sat     <= &count_n;
        end
    end

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: a queue-based reference model is
// checked every cycle, plus literal expectations from the hand-worked plan.
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset, din, en, overlap_en, pattern_load, count_clr;
    logic [3:0] pattern_in;

    logic       dout_a, sat_a, dout_b, sat_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int n_chk  = 0;
    int n_fail = 0;
    bit started = 0;

    // Reference model state
    bit         m_q[$];
    logic [3:0] m_pat;
    bit         m_dout;
    int         m_c8, m_c2;
    bit         ovl;

    always #5 clk = ~clk;

    seq_detector_param u_dut_a (
        .clk(clk), .reset(reset), .din(din), .en(en),
        .overlap_en(overlap_en), .pattern_in(pattern_in),
        .pattern_load(pattern_load), .count_clr(count_clr),
        .dout(dout_a), .match_count(cnt_a), .cnt_sat(sat_a)
    );

    seq_detector_param #(.CNT_W(2)) u_dut_b (
        .clk(clk), .reset(reset), .din(din), .en(en),
        .overlap_en(overlap_en), .pattern_in(pattern_in),
        .pattern_load(pattern_load), .count_clr(count_clr),
        .dout(dout_b), .match_count(cnt_b), .cnt_sat(sat_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat_inc(input int c, input int mx);
        return (c >= mx) ? mx : c + 1;
    endfunction

    task automatic model_edge(input bit r, input bit d, input bit e,
                              input bit l, input logic [3:0] p,
                              input bit c);
        bit         mt;
        logic [3:0] v;
        mt = 0;
        if (r) begin
            m_q.delete();
            m_pat  = 4'b1001;
            m_dout = 0;
            m_c8   = 0;
            m_c2   = 0;
            return;
        end
        if (l) begin
            m_pat = p;
            m_q.delete();
            m_dout = 0;
        end else if (e) begin
            m_q.push_back(d);
            if (m_q.size() > 4) void'(m_q.pop_front());
            v = '0;
            foreach (m_q[i]) v = {v[2:0], m_q[i]};
            mt = (m_q.size() == 4) && (v == m_pat);
            m_dout = mt;
            if (mt && !ovl) m_q.delete();
        end
        if (c) begin
            m_c8 = mt ? 1 : 0;
            m_c2 = mt ? 1 : 0;
        end else if (mt) begin
            m_c8 = sat_inc(m_c8, 255);
            m_c2 = sat_inc(m_c2, 3);
        end
    endtask

    task automatic step(input bit r, input bit d, input bit e,
                        input bit l, input logic [3:0] p, input bit c);
        reset        = r;
        din          = d;
        en           = e;
        overlap_en   = ovl;
        pattern_load = l;
        pattern_in   = p;
        count_clr    = c;
        @(posedge clk);
        model_edge(r, d, e, l, p, c);
        @(negedge clk);
    endtask

    task automatic bit_in(input bit d);
        step(0, d, 1, 0, 4'h0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 4'h0, 0);
    endtask

    // Every cycle: DUT outputs against the reference model.
    always @(negedge clk) begin
        if (started) begin
            chk("model_dout_a", int'(dout_a), int'(m_dout));
            chk("model_cnt_a", int'(cnt_a), m_c8);
            chk("model_sat_a", int'(sat_a), int'(m_c8 == 255));
            chk("model_dout_b", int'(dout_b), int'(m_dout));
            chk("model_cnt_b", int'(cnt_b), m_c2);
            chk("model_sat_b", int'(sat_b), int'(m_c2 == 3));
        end
    end

    initial begin
        logic [6:0] s1;
        ovl = 1;
        do_reset();
        do_reset();
        started = 1;
        chk("rst_dout", int'(dout_a), 0);
        chk("rst_cnt", int'(cnt_a), 0);
        chk("rst_sat", int'(sat_b), 0);

        // Overlap: 1001001 -> matches at edges 4 and 7
        s1 = 7'b1001001;
        for (int i = 6; i >= 0; i--) begin
            bit_in(s1[i]);
            if (i == 3) chk("ovl_e4_dout", int'(dout_a), 1);
            if (i == 2) chk("ovl_e5_dout", int'(dout_a), 0);
        end
        chk("ovl_e7_dout", int'(dout_a), 1);
        chk("ovl_cnt", int'(cnt_a), 2);

        // Non-overlap: same stream -> one match only
        do_reset();
        ovl = 0;
        for (int i = 6; i >= 0; i--) begin
            bit_in(s1[i]);
            if (i == 3) chk("novl_e4_dout", int'(dout_a), 1);
        end
        chk("novl_e7_dout", int'(dout_a), 0);
        chk("novl_cnt", int'(cnt_a), 1);
        // fill is 3 here: one more 0 gives hist 0010, not a match
        bit_in(0);
        chk("novl_e8_dout", int'(dout_a), 0);
        ovl = 1;

        // Reset mid-stream
        do_reset();
        bit_in(1); bit_in(0); bit_in(0);
        do_reset();
        bit_in(1);
        chk("mrst_dout", int'(dout_a), 0);
        chk("mrst_cnt", int'(cnt_a), 0);
        bit_in(1); bit_in(0); bit_in(0); bit_in(1);
        chk("mrst_match", int'(dout_a), 1);

        // Pattern load while fill = 3, din ignored on the load edge
        do_reset();
        bit_in(1); bit_in(0); bit_in(0);
        step(0, 1, 1, 1, 4'b1011, 0);
        chk("load_dout", int'(dout_a), 0);
        s1 = 7'b1011011;
        for (int i = 6; i >= 0; i--) begin
            bit_in(s1[i]);
            if (i == 4) chk("load_e3_dout", int'(dout_a), 0);
            if (i == 3) chk("load_e4_dout", int'(dout_a), 1);
        end
        chk("load_e7_dout", int'(dout_a), 1);
        chk("load_cnt", int'(cnt_a), 2);

        // en gating
        do_reset();
        bit_in(1); bit_in(0);
        step(0, 1, 0, 0, 4'h0, 0);
        step(0, 0, 0, 0, 4'h0, 0);
        bit_in(0); bit_in(1);
        chk("en_match", int'(dout_a), 1);
        step(0, 0, 0, 0, 4'h0, 0);
        step(0, 1, 0, 0, 4'h0, 0);
        chk("en_hold_dout", int'(dout_a), 1);
        chk("en_hold_cnt", int'(cnt_a), 1);

        // count_clr alone on a non-matching sample
        bit_in(0);
        step(0, 0, 1, 0, 4'h0, 1);
        chk("clr_cnt", int'(cnt_a), 0);

        // Saturation with CNT_W = 2: five overlapping matches
        do_reset();
        bit_in(1);
        for (int m = 1; m <= 5; m++) begin
            bit_in(0); bit_in(0); bit_in(1);
            chk("sat_cnt_b", int'(cnt_b), (m < 3) ? m : 3);
            chk("sat_flag_b", int'(sat_b), int'(m >= 3));
        end
        chk("sat_cnt_a", int'(cnt_a), 5);
        // count_clr coinciding with a match
        bit_in(0); bit_in(0);
        step(0, 1, 1, 0, 4'h0, 1);
        chk("clrm_cnt_b", int'(cnt_b), 1);
        chk("clrm_sat_b", int'(sat_b), 0);
        chk("clrm_cnt_a", int'(cnt_a), 1);
        chk("clrm_dout", int'(dout_a), 1);

        started = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
